spi_reg_master: RTL and testbench
=================================

SPI_REG_MASTER -- requirements
Module: spi_reg_master

Interface
REQ-001 Parameter AWIDTH, default 8, register address width in bits.
REQ-002 Parameter DWIDTH, default 16, register data width in bits.
REQ-003 Parameter CLKDIV, default 4, SCLK half-period in clk cycles; legal range 1..255.
REQ-004 Parameter CPOL, default 0, SCLK idle level.
REQ-005 Parameter CPHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-006 Parameter CS_SETUP, default 2, clk cycles from CS low to the first SCLK edge; minimum 1.
REQ-007 Parameter CS_HOLD, default 2, clk cycles from the last SCLK edge to CS high; minimum 1.
REQ-008 Parameter CS_GAP, default 4, minimum clk cycles CS stays high between frames; minimum 1.
REQ-009 clk  in  1  single system clock; all logic is on its rising edge.
REQ-010 rst  in  1  asynchronous, active-high reset.
REQ-011 req_valid  in  1  frame request.
REQ-012 req_ready  out  1  block can accept a request.
REQ-013 req_addr  in  AWIDTH  address field, captured on accept.
REQ-014 req_wdata  in  DWIDTH  data field, captured on accept.
REQ-015 done  out  1  one-cycle pulse at end of frame.
REQ-016 rdata  out  DWIDTH  last DWIDTH bits received on MISO, valid from done until the next done.
REQ-017 busy  out  1  high whenever state is not IDLE.
REQ-018 spi_cs  out  1  active-low chip select.
REQ-019 spi_clk  out  1  SCLK.
REQ-020 spi_mosi  out  1  serial data out.
REQ-021 spi_miso  in  1  serial data in, sampled without a synchroniser.

Function
REQ-022 Frame = {addr, wdata}, N = AWIDTH+DWIDTH bits, MSB first; one frame per accepted request.
REQ-023 Accept = req_valid & req_ready at a clk edge; req_ready is high only in IDLE.
REQ-024 FSM states: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE, one frame per pass, no other transitions except reset.
REQ-025 IDLE: spi_cs=1, spi_clk=CPOL, spi_mosi=0; on accept, latch the frame into the shift register and go to SETUP.
REQ-026 SETUP: spi_cs=0 for exactly CS_SETUP cycles; if CPHA=0, MSB is on spi_mosi for the whole of SETUP.
REQ-027 SHIFT: 2N half-periods of CLKDIV cycles each; spi_clk toggles at each half-period boundary, giving N leading and N trailing edges.
REQ-028 CPHA=0: MISO is sampled at each leading edge; MOSI advances to the next bit at each trailing edge except the last.
REQ-029 CPHA=1: MOSI advances (first edge drives the MSB) at each leading edge; MISO is sampled at each trailing edge.
REQ-030 The sampled bit is shifted into a receive register MSB-first; the bit counter ends the SHIFT state after exactly N samples.
REQ-031 HOLD: spi_clk=CPOL, spi_cs=0 for CS_HOLD cycles; spi_mosi holds its last value.
REQ-032 On the HOLD->GAP transition: spi_cs=1, spi_mosi=0, rdata <= rx[DWIDTH-1:0], done=1 for one cycle.
REQ-033 GAP: spi_cs=1 for CS_GAP cycles; then IDLE; req_ready rises the cycle after GAP ends.
REQ-034 Frame length is CS_SETUP + 2N*CLKDIV + CS_HOLD clk cycles of spi_cs low; back-to-back period = that + CS_GAP + 1.
REQ-035 req_valid held during a frame is not accepted until IDLE; no request is dropped or duplicated.
REQ-036 req_addr and req_wdata changing after accept do not affect the frame in flight.
REQ-037 All SPI outputs are registered (glitch-free).

Reset
REQ-038 rst high asynchronously forces IDLE: spi_cs=1, spi_clk=CPOL, spi_mosi=0, done=0, busy=0, req_ready=0 while rst is high, rdata=0, counters=0.
REQ-039 Reset mid-frame aborts the frame immediately with no done pulse; req_ready=1 in the first cycle after rst deasserts.

Verification
REQ-040 Mode 0, AWIDTH=8, DWIDTH=16, CLKDIV=4: write addr 0x12, data 0x00AA -> MOSI stream 0x1200AA, 24 rising edges, spi_cs low for 2+192+2=196 cycles, one done pulse.
REQ-041 Loopback slave returning 0xBEEF in the data phase: read addr 0x80 -> rdata=0xBEEF at done, held until the next done.
REQ-042 Each of the four CPOL/CPHA settings with a mode-matched slave model: write 0xA5/0x5A5A, read back 0x5A5A -> data correct, idle SCLK = CPOL.
REQ-043 Four requests with req_valid held continuously -> four frames, CS high >= CS_GAP cycles between frames, exactly four done pulses.
REQ-044 rst asserted during bit 10 of a frame -> spi_cs=1 within the same cycle (asynchronous), no done pulse, and the next request runs a full correct frame.
REQ-045 CLKDIV=1, CS_SETUP=CS_HOLD=CS_GAP=1 -> SCLK period of 2 clk cycles, frame timing per REQ-034, data correct.

Source files
------------

// File: rtl/spi_reg_master_if.sv
// Request/response bus of the SPI register master: frame requests in, done/rdata/busy out.
interface spi_reg_master_if #(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 16
);
  logic              req_valid;
  logic              req_ready;
  logic [AWIDTH-1:0] req_addr;
  logic [DWIDTH-1:0] req_wdata;
  logic              done;
  logic [DWIDTH-1:0] rdata;
  logic              busy;

  // Requester side
  modport master (
    output req_valid, req_addr, req_wdata,
    input  req_ready, done, rdata, busy
  );

  // SPI master block side
  modport slave (
    input  req_valid, req_addr, req_wdata,
    output req_ready, done, rdata, busy
  );
endinterface

// File: rtl/spi_reg_master.sv
// SPI master that shifts one {addr, wdata} frame per accepted request, MSB first,
// with programmable CPOL/CPHA, SCLK divider and chip-select setup/hold/gap timing.
module spi_reg_master #(
  parameter int AWIDTH   = 8,
  parameter int DWIDTH   = 16,
  parameter int CLKDIV   = 4,
  parameter int CPOL     = 0,
  parameter int CPHA     = 0,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_reg_master_if.slave      bus,
  output logic                 spi_cs,
  output logic                 spi_clk,
  output logic                 spi_mosi,
  input  logic                 spi_miso
);

  localparam int   N      = AWIDTH + DWIDTH;
  localparam int   EW     = $clog2(2 * N + 1);
  localparam int   CW     = 16;
  localparam logic CPOL_L = (CPOL != 0);
  localparam logic CPHA_L = (CPHA != 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [EW-1:0]     ecnt_q, ecnt_d;
  logic [N-1:0]      tx_q, tx_d;
  logic [DWIDTH-1:0] rx_q, rx_d;
  logic [DWIDTH-1:0] rdata_q, rdata_d;
  logic              cs_q, cs_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              accept;
  logic              do_edge;
  logic              leading;

  // State and registered SPI/bus outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= {CW{1'b0}};
      ecnt_q  <= {EW{1'b0}};
      tx_q    <= {N{1'b0}};
      rx_q    <= {DWIDTH{1'b0}};
      rdata_q <= {DWIDTH{1'b0}};
      cs_q    <= 1'b1;
      sclk_q  <= CPOL_L;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ecnt_q  <= ecnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign accept = bus.req_valid && (state_q == S_IDLE);

  // Next-state, counters, shift registers and output levels
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ecnt_d  = ecnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;
    do_edge = 1'b0;
    leading = 1'b0;

    case (state_q)
      S_IDLE: begin
        cs_d   = 1'b1;
        sclk_d = CPOL_L;
        mosi_d = 1'b0;
        cnt_d  = {CW{1'b0}};
        ecnt_d = {EW{1'b0}};
        if (accept) begin
          state_d = S_SETUP;
          cs_d    = 1'b0;
          tx_d    = {bus.req_addr, bus.req_wdata};
          if (CPHA_L) begin
            mosi_d = 1'b0;
          end else begin
            mosi_d = bus.req_addr[AWIDTH-1];
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        if (cnt_q == CW'(CS_SETUP - 1)) begin
          state_d = S_SHIFT;
          cnt_d   = {CW{1'b0}};
          do_edge = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      // One SCLK edge opens each half-period; the final half-period runs out at idle level.
      S_SHIFT: begin
        if (cnt_q == CW'(CLKDIV - 1)) begin
          cnt_d = {CW{1'b0}};
          if (ecnt_q == EW'(2 * N)) begin
            state_d = S_HOLD;
          end else begin
            do_edge = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == CW'(CS_HOLD - 1)) begin
          state_d = S_GAP;
          cnt_d   = {CW{1'b0}};
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
          rdata_d = rx_q;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == CW'(CS_GAP - 1)) begin
          state_d = S_IDLE;
          cnt_d   = {CW{1'b0}};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cs_d    = 1'b1;
        sclk_d  = CPOL_L;
        mosi_d  = 1'b0;
        cnt_d   = {CW{1'b0}};
        ecnt_d  = {EW{1'b0}};
      end
    endcase

    if (do_edge) begin
      ecnt_d  = ecnt_q + EW'(1);
      sclk_d  = ~sclk_q;
      leading = ~ecnt_q[0];
      if (leading) begin
        if (CPHA_L) begin
          mosi_d = tx_q[N-1];
          tx_d   = tx_q << 1;
        end else begin
          rx_d = DWIDTH'({rx_q, spi_miso});
        end
      end else begin
        if (CPHA_L) begin
          rx_d = DWIDTH'({rx_q, spi_miso});
        end else if (ecnt_q != EW'(2 * N - 1)) begin
          tx_d   = tx_q << 1;
          mosi_d = tx_q[N-2];
        end else begin
          tx_d = tx_q;
        end
      end
    end else begin
      leading = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  assign bus.req_ready = (state_q == S_IDLE) && !rst;
  assign bus.done      = done_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = busy_q;
  assign spi_cs        = cs_q;
  assign spi_clk       = sclk_q;
  assign spi_mosi      = mosi_q;

endmodule

// File: tb/tb_spi_reg_master.sv
// Directed bench: five masters (four SPI modes plus a fastest-timing build) against mode-matched slave models.
module tb_spi_reg_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  valid = 5'b00000;
  logic [7:0]  req_addr = 8'h00;
  logic [15:0] req_wdata = 16'h0000;
  logic [15:0] resp = 16'h0000;

  logic        ready_a [5];
  logic        done_a  [5];
  logic        busy_a  [5];
  logic        cs_a    [5];
  logic        sclk_a  [5];
  logic        mosi_a  [5];
  logic [15:0] rdata_a [5];
  logic [23:0] cap_a   [5];
  int          rise_a  [5];
  int          cslen_a [5];
  int          gap_a   [5];
  int          dcnt_a  [5];

  int cyc      = 0;
  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [4:0] M_CPOL = 5'b01100;
  localparam logic [4:0] M_CPHA = 5'b01010;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    localparam int P_CPOL = int'(M_CPOL[g]);
    localparam int P_CPHA = int'(M_CPHA[g]);
    localparam int P_DIV  = (g == 4) ? 1 : 4;
    localparam int P_SH   = (g == 4) ? 1 : 2;
    localparam int P_GAP  = (g == 4) ? 1 : 4;

    logic        miso = 1'b0;
    logic [23:0] sbuf = 24'h000000;
    logic [23:0] cap  = 24'h000000;
    logic        prev_cs_s  = 1'b1;
    logic        prev_clk_s = 1'(P_CPOL);
    logic        prev_cs_c  = 1'b1;
    int          rise = 0;
    int          lo_cnt = 0;
    int          hi_cnt = 0;
    int          cs_len = 0;
    int          gap_last = 0;
    int          done_cnt = 0;

    spi_reg_master_if #(.AWIDTH(8), .DWIDTH(16)) bus ();

    spi_reg_master #(
      .AWIDTH(8), .DWIDTH(16), .CLKDIV(P_DIV), .CPOL(P_CPOL), .CPHA(P_CPHA),
      .CS_SETUP(P_SH), .CS_HOLD(P_SH), .CS_GAP(P_GAP)
    ) u_dut (
      .clk(clk), .rst(rst), .bus(bus),
      .spi_cs(cs_a[g]), .spi_clk(sclk_a[g]), .spi_mosi(mosi_a[g]), .spi_miso(miso)
    );

    assign bus.req_valid = valid[g];
    assign bus.req_addr  = req_addr;
    assign bus.req_wdata = req_wdata;
    assign ready_a[g]    = bus.req_ready;
    assign done_a[g]     = bus.done;
    assign busy_a[g]     = bus.busy;
    assign rdata_a[g]    = bus.rdata;
    assign cap_a[g]      = cap;
    assign rise_a[g]     = rise;
    assign cslen_a[g]    = cs_len;
    assign gap_a[g]      = gap_last;
    assign dcnt_a[g]     = done_cnt;

    // Slave model: loads {8'h00, resp} at CS fall, shifts per its CPOL/CPHA
    always @(cs_a[g] or sclk_a[g]) begin
      if (cs_a[g] !== 1'b0) begin
        sbuf = sbuf;
      end else if (prev_cs_s) begin
        sbuf = {8'h00, resp};
        if (P_CPHA == 0) miso = sbuf[23];
      end else if (sclk_a[g] !== prev_clk_s) begin
        if (sclk_a[g] == 1'b1) rise++;
        if (sclk_a[g] != 1'(P_CPOL)) begin
          if (P_CPHA == 0) cap = {cap[22:0], mosi_a[g]};
          else begin miso = sbuf[23]; sbuf = sbuf << 1; end
        end else begin
          if (P_CPHA == 0) begin sbuf = sbuf << 1; miso = sbuf[23]; end
          else cap = {cap[22:0], mosi_a[g]};
        end
      end
      prev_cs_s  = (cs_a[g] !== 1'b0);
      prev_clk_s = sclk_a[g];
    end

    // CS low/high cycle counts and done pulse cycles
    always @(posedge clk) begin
      if (cs_a[g] == 1'b0) lo_cnt <= prev_cs_c ? 1 : lo_cnt + 1;
      else                 hi_cnt <= prev_cs_c ? hi_cnt + 1 : 1;
      if (cs_a[g] == 1'b1 && !prev_cs_c) cs_len <= lo_cnt;
      if (cs_a[g] == 1'b0 && prev_cs_c)  gap_last <= hi_cnt;
      if (done_a[g] == 1'b1) done_cnt <= done_cnt + 1;
      prev_cs_c <= (cs_a[g] !== 1'b0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int k, input logic [7:0] a, input logic [15:0] d);
    int t;
    t = 0;
    @(negedge clk);
    req_addr  = a;
    req_wdata = d;
    valid[k]  = 1'b1;
    while (ready_a[k] !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("accept_wait", 32'(t < 2000), 32'd1);
    @(posedge clk);
    #1;
    valid[k]  = 1'b0;
    req_addr  = ~a;
    req_wdata = ~d;
  endtask

  task automatic wait_done(input int k);
    int t;
    t = 0;
    while (done_a[k] !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("done_wait", 32'(t < 3000), 32'd1);
  endtask

  task automatic b2b(input int k, input int nf, input int period, input int gap);
    int n, t, d0;
    int acc [8];
    acc = '{default: 0};
    d0 = dcnt_a[k];
    n = 0;
    t = 0;
    @(negedge clk);
    req_addr  = 8'h3C;
    req_wdata = 16'h9669;
    valid[k]  = 1'b1;
    while (t < 5000) begin
      if (ready_a[k] === 1'b1) begin
        acc[n] = cyc;
        n++;
        if (n == nf) break;
      end
      @(negedge clk);
      t++;
    end
    chk("b2b_accepts", n, nf);
    @(posedge clk);
    #1;
    valid[k] = 1'b0;
    t = 0;
    while (dcnt_a[k] - d0 < nf && t < 5000) begin
      @(negedge clk);
      t++;
    end
    repeat (2 * period) @(negedge clk);
    chk("b2b_done_count", dcnt_a[k] - d0, nf);
    chk("b2b_cs_gap", gap_a[k], gap);
    for (int i = 1; i < nf; i++) chk("b2b_period", acc[i] - acc[i-1], period);
  endtask

  initial begin
    int r0, d0, t;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cs",         32'(cs_a[0]),    32'd1);
    chk("rst_sclk_cpol0", 32'(sclk_a[0]),  32'd0);
    chk("rst_sclk_cpol1", 32'(sclk_a[2]),  32'd1);
    chk("rst_mosi",       32'(mosi_a[0]),  32'd0);
    chk("rst_done",       32'(done_a[0]),  32'd0);
    chk("rst_busy",       32'(busy_a[0]),  32'd0);
    chk("rst_ready",      32'(ready_a[0]), 32'd0);
    chk("rst_rdata",      32'(rdata_a[0]), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(ready_a[0]), 32'd1);

    // Mode 0 write 0x12 / 0x00AA
    resp = 16'h1234;
    r0 = rise_a[0];
    d0 = dcnt_a[0];
    issue(0, 8'h12, 16'h00AA);
    @(negedge clk);
    chk("setup_busy",  32'(busy_a[0]),  32'd1);
    chk("setup_ready", 32'(ready_a[0]), 32'd0);
    chk("setup_cs",    32'(cs_a[0]),    32'd0);
    chk("setup_mosi0", 32'(mosi_a[0]),  32'd0);
    wait_done(0);
    chk("w_rdata", 32'(rdata_a[0]), 32'h1234);
    repeat (3) @(negedge clk);
    chk("w_mosi_stream", 32'(cap_a[0]), 32'h1200AA);
    chk("w_rising_edges", rise_a[0] - r0, 24);
    chk("w_cs_low_len", cslen_a[0], 196);
    chk("w_done_pulses", dcnt_a[0] - d0, 1);
    chk("w_idle_sclk", 32'(sclk_a[0]), 32'd0);

    // Read 0x80 returning 0xBEEF, held until the next done
    resp = 16'hBEEF;
    issue(0, 8'h80, 16'h0000);
    @(negedge clk);
    chk("setup_mosi1", 32'(mosi_a[0]), 32'd1);
    wait_done(0);
    chk("r_rdata", 32'(rdata_a[0]), 32'hBEEF);
    repeat (20) @(negedge clk);
    chk("r_rdata_hold", 32'(rdata_a[0]), 32'hBEEF);
    chk("r_mosi_stream", 32'(cap_a[0]), 32'h800000);
    resp = 16'h1111;
    issue(0, 8'h01, 16'h0203);
    repeat (50) @(negedge clk);
    chk("r_rdata_hold_midframe", 32'(rdata_a[0]), 32'hBEEF);
    wait_done(0);
    chk("r2_rdata", 32'(rdata_a[0]), 32'h1111);
    repeat (3) @(negedge clk);
    chk("r2_stream_after_input_change", 32'(cap_a[0]), 32'h010203);

    // All four CPOL/CPHA modes
    for (int k = 0; k < 4; k++) begin
      resp = 16'h5A5A;
      r0 = rise_a[k];
      issue(k, 8'hA5, 16'h5A5A);
      wait_done(k);
      chk("mode_rdata", 32'(rdata_a[k]), 32'h5A5A);
      repeat (3) @(negedge clk);
      chk("mode_mosi_stream", 32'(cap_a[k]), 32'hA55A5A);
      chk("mode_rising_edges", rise_a[k] - r0, 24);
      chk("mode_cs_low_len", cslen_a[k], 196);
      chk("mode_idle_sclk", 32'(sclk_a[k]), 32'(k >= 2));
    end

    // Held req_valid: back-to-back frames
    b2b(0, 4, 201, 5);
    b2b(4, 2, 52, 2);

    // Reset during bit 10
    resp = 16'h7777;
    d0 = dcnt_a[0];
    r0 = rise_a[0];
    issue(0, 8'h33, 16'h1234);
    t = 0;
    while (rise_a[0] - r0 < 10 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("bit10_wait", 32'(t < 1000), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_cs_async", 32'(cs_a[0]),    32'd1);
    chk("abort_sclk",     32'(sclk_a[0]),  32'd0);
    chk("abort_busy",     32'(busy_a[0]),  32'd0);
    chk("abort_ready",    32'(ready_a[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_ready_after_rst", 32'(ready_a[0]), 32'd1);
    repeat (300) @(negedge clk);
    chk("abort_no_done", dcnt_a[0] - d0, 0);
    resp = 16'h0F0F;
    issue(0, 8'h12, 16'h00AA);
    wait_done(0);
    chk("post_abort_rdata", 32'(rdata_a[0]), 32'h0F0F);
    repeat (3) @(negedge clk);
    chk("post_abort_stream", 32'(cap_a[0]), 32'h1200AA);
    chk("post_abort_cs_len", cslen_a[0], 196);

    // CLKDIV=1 with minimum CS timing
    resp = 16'hC3C3;
    r0 = rise_a[4];
    issue(4, 8'h5A, 16'h0F0F);
    wait_done(4);
    chk("fast_rdata", 32'(rdata_a[4]), 32'hC3C3);
    repeat (3) @(negedge clk);
    chk("fast_stream", 32'(cap_a[4]), 32'h5A0F0F);
    chk("fast_cs_len", cslen_a[4], 50);
    chk("fast_rising_edges", rise_a[4] - r0, 24);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
